// File: rtl/tt_sweep_checker_if.sv
// tt_sweep_checker_if
// Purpose: bundles the sweep checker's control, status and DUT-facing
// signals so the checker and its environment connect through one port.
// Signals:
//   start            request a sweep (environment -> checker)
//   dut_in           vector driven to the combinational DUT, MSB = first input
//   dut_out          DUT output fed back to the checker
//   busy             sweep in progress (through the DONE cycle)
//   done             one-cycle pulse at sweep completion
//   pass             last completed sweep had zero mismatches
//   fail_count       mismatches in the last or current sweep
//   first_fail_valid at least one mismatch seen in this sweep
//   first_fail_vec   vector index of the first mismatch
// Modports: master = checker side, slave = environment/DUT side.
interface tt_sweep_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic [N_IN-1:0] dut_in;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   fail_count;
  logic            first_fail_valid;
  logic [N_IN-1:0] first_fail_vec;

  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, fail_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
// Purpose: exhaustively sweeps every input vector of a combinational block,
// waits SETTLE cycles per vector, samples the block's single output and
// compares it with the matching bit of the EXPECTED truth table. Reports
// pass/fail, a mismatch count and the first failing vector.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tt_sweep_checker_if master modport (start, dut_in, dut_out,
//          busy, done, pass, fail_count, first_fail_valid, first_fail_vec)
// Every output is driven straight from a register; dut_out only reaches
// state through the SAMPLE compare.
module tt_sweep_checker #(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'hE8,
  parameter int                 SETTLE   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tt_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

  localparam logic [N_IN-1:0] LAST_IDX    = '1;
  localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   FAIL_ONE    = (N_IN+1)'(1);
  localparam logic [N_IN:0]   FAIL_MAX    = (N_IN+1)'(2**N_IN);
  localparam logic [3:0]      SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam state_e          HOLD_STATE  = (SETTLE == 0) ? SAMPLE : WAIT;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [3:0]      settle_q, settle_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   fail_count_q, fail_count_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;

  logic            isMismatch;
  logic [N_IN:0]   failNext;

  // Compare of the currently held vector against the truth table, and the
  // mismatch count this sample would produce (saturating, even though a
  // single sweep can never exceed FAIL_MAX).
  always_comb begin
    isMismatch = (bus.dut_out != EXPECTED[idx_q]);
    failNext   = fail_count_q;
    if (isMismatch && (fail_count_q != FAIL_MAX)) begin
      failNext = fail_count_q + FAIL_ONE;
    end
  end

  // Next-state logic for the sweep FSM. The vector index doubles as the
  // value driven on dut_in, so it keeps its last value through DONE. The
  // terminal test looks at the full index width so the index never wraps
  // back to zero inside a sweep. pass is decided on the way into DONE from
  // the count that includes the final sample, so it is already valid
  // while done is high.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    ffv_d        = ffv_q;
    ffvec_d      = ffvec_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d        = '0;
          settle_d     = '0;
          fail_count_d = '0;
          ffv_d        = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = HOLD_STATE;
        end
      end

      WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      SAMPLE: begin
        fail_count_d = failNext;
        if (isMismatch && !ffv_q) begin
          ffv_d   = 1'b1;
          ffvec_d = idx_q;
        end
        if (idx_q != LAST_IDX) begin
          idx_d    = idx_q + IDX_ONE;
          settle_d = '0;
          state_d  = HOLD_STATE;
        end else begin
          done_d  = 1'b1;
          pass_d  = (failNext == '0);
          state_d = DONE;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state register for the whole FSM; reset aborts any sweep in
  // progress and discards its results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= '0;
      ffv_q        <= 1'b0;
      ffvec_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      ffv_q        <= ffv_d;
      ffvec_q      <= ffvec_d;
    end
  end

  assign bus.dut_in           = idx_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.fail_count       = fail_count_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker
// Purpose: drives two sweep checkers (SETTLE=2 and SETTLE=0) against a
// behavioural combinational DUT described by a truth table, and compares
// sweep timing and results against a reference model derived from the
// 3-input majority function.
module tb_tt_sweep_checker;

  logic       clk;
  logic       rst_n;
  logic       startA, startB;
  logic [7:0] tableA, tableB;
  logic [7:0] majTable;
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tt_sweep_checker_if #(.N_IN(3)) busA ();
  tt_sweep_checker_if #(.N_IN(3)) busB ();

  // The DUT under check is a pure lookup of its current input vector.
  assign busA.start   = startA;
  assign busA.dut_out = tableA[busA.dut_in];
  assign busB.start   = startB;
  assign busB.dut_out = tableB[busB.dut_in];

  tt_sweep_checker #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE(2)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.master)
  );

  tt_sweep_checker #(.N_IN(3), .EXPECTED(8'hE8), .SETTLE(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.master)
  );

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Snapshot of one checker's outputs.
  task automatic readOuts(input int sel, output logic [2:0] din, output logic bsy,
                          output logic dn, output logic ps, output logic [3:0] fc,
                          output logic fv, output logic [2:0] fvec);
    if (sel == 0) begin
      din = busA.dut_in; bsy = busA.busy; dn = busA.done; ps = busA.pass;
      fc = busA.fail_count; fv = busA.first_fail_valid; fvec = busA.first_fail_vec;
    end else begin
      din = busB.dut_in; bsy = busB.busy; dn = busB.done; ps = busB.pass;
      fc = busB.fail_count; fv = busB.first_fail_valid; fvec = busB.first_fail_vec;
    end
  endtask

  task automatic setStart(input int sel, input logic val);
    if (sel == 0) startA = val;
    else startB = val;
  endtask

  // Reference model: number of vectors where the DUT disagrees with majority.
  function automatic int modelFails(input logic [7:0] tbl);
    int c = 0;
    for (int k = 0; k < 8; k++) if (tbl[k] != majTable[k]) c++;
    return c;
  endfunction

  // Reference model: lowest vector where the DUT disagrees with majority.
  function automatic int modelFirst(input logic [7:0] tbl);
    for (int k = 0; k < 8; k++) if (tbl[k] != majTable[k]) return k;
    return 0;
  endfunction

  task automatic checkResetValues(input int sel, input string tag);
    logic [2:0] din, fvec; logic bsy, dn, ps, fv; logic [3:0] fc;
    readOuts(sel, din, bsy, dn, ps, fc, fv, fvec);
    checkOutput({tag, " dut_in"}, 32'(din), 32'(0));
    checkOutput({tag, " busy"}, 32'(bsy), 32'(0));
    checkOutput({tag, " done"}, 32'(dn), 32'(0));
    checkOutput({tag, " pass"}, 32'(ps), 32'(0));
    checkOutput({tag, " fail_count"}, 32'(fc), 32'(0));
    checkOutput({tag, " first_fail_valid"}, 32'(fv), 32'(0));
    checkOutput({tag, " first_fail_vec"}, 32'(fvec), 32'(0));
  endtask

  // One full sweep on checker sel with DUT truth table tbl. Cycle n is the
  // cycle ending at edge n, with start accepted at edge 0. restartAt>0
  // pulses start again during that cycle (must be ignored).
  task automatic applyStimulus(input string name, input int sel, input logic [7:0] tbl,
                               input int restartAt);
    int settle, lastCycle, doneCnt, doneAt, expFails, vecExp;
    logic [2:0] din, fvec; logic bsy, dn, ps, fv; logic [3:0] fc;
    settle    = (sel == 0) ? 2 : 0;
    lastCycle = 8 * (settle + 1) + 1;
    doneCnt   = 0;
    doneAt    = -1;
    expFails  = modelFails(tbl);
    if (sel == 0) tableA = tbl; else tableB = tbl;
    @(negedge clk);
    setStart(sel, 1'b1);
    @(negedge clk);
    for (int n = 1; n <= lastCycle + 2; n++) begin
      setStart(sel, (n == restartAt) ? 1'b1 : 1'b0);
      readOuts(sel, din, bsy, dn, ps, fc, fv, fvec);
      if (dn) begin
        doneCnt++;
        doneAt = n;
      end
      if (n <= lastCycle) begin
        vecExp = (n - 1) / (settle + 1);
        if (vecExp > 7) vecExp = 7;
        checkOutput({name, " dut_in"}, 32'(din), 32'(vecExp));
        checkOutput({name, " busy"}, 32'(bsy), 32'(1));
      end
      @(negedge clk);
    end
    readOuts(sel, din, bsy, dn, ps, fc, fv, fvec);
    checkOutput({name, " done count"}, 32'(doneCnt), 32'(1));
    checkOutput({name, " done cycle"}, 32'(doneAt), 32'(lastCycle));
    checkOutput({name, " busy idle"}, 32'(bsy), 32'(0));
    checkOutput({name, " pass"}, 32'(ps), 32'(expFails == 0));
    checkOutput({name, " fail_count"}, 32'(fc), 32'(expFails));
    checkOutput({name, " first_fail_valid"}, 32'(fv), 32'(expFails != 0));
    if (expFails != 0) begin
      checkOutput({name, " first_fail_vec"}, 32'(fvec), 32'(modelFirst(tbl)));
    end
  endtask

  initial begin
    int doneQ[$];
    logic [2:0] din, fvec; logic bsy, dn, ps, fv; logic [3:0] fc;
    logic [7:0] rtbl;

    // Majority built from its definition: at least two of {A,B,C} high.
    for (int v = 0; v < 8; v++) begin
      majTable[v] = (((v >> 2) & 1) + ((v >> 1) & 1) + (v & 1)) >= 2;
    end
    tableA = majTable;
    tableB = majTable;
    startA = 1'b0;
    startB = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues(0, "reset A");
    checkResetValues(1, "reset B");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] golden, inverted and single-fault sweeps");
    applyStimulus("golden", 0, majTable, 0);
    applyStimulus("inverted", 0, ~majTable, 0);
    applyStimulus("fault101", 0, majTable & 8'hDF, 0);

    $display("[TB] SETTLE=0 sweep with ignored restart");
    applyStimulus("settle0", 1, majTable, 4);

    $display("[TB] reset mid-sweep");
    tableA = majTable;
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues(0, "midreset");
    for (int n = 12; n < 45; n++) begin
      readOuts(0, din, bsy, dn, ps, fc, fv, fvec);
      if (dn || bsy) checkOutput("midreset no activity", 32'({dn, bsy}), 32'(0));
      @(negedge clk);
      if (n == 13) rst_n = 1'b1;
    end
    checkResetValues(0, "after reset");
    applyStimulus("post-reset", 0, majTable, 0);

    $display("[TB] start held across two sweeps");
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 56; n++) begin
      if (n == 40) startA = 1'b0;
      readOuts(0, din, bsy, dn, ps, fc, fv, fvec);
      if (dn) doneQ.push_back(n);
      if (n == 26) begin
        checkOutput("held idle busy", 32'(bsy), 32'(0));
        checkOutput("held pass1", 32'(ps), 32'(1));
      end
      if (n == 27) begin
        checkOutput("held restart busy", 32'(bsy), 32'(1));
        checkOutput("held restart pass", 32'(ps), 32'(0));
        checkOutput("held restart dut_in", 32'(din), 32'(0));
      end
      if (n == 52) checkOutput("held pass2", 32'(ps), 32'(1));
      if (n == 56) checkOutput("held stop busy", 32'(bsy), 32'(0));
      @(negedge clk);
    end
    checkOutput("held done count", 32'(doneQ.size()), 32'(2));
    if (doneQ.size() == 2) begin
      checkOutput("held done1 cycle", 32'(doneQ[0]), 32'(25));
      checkOutput("held done2 cycle", 32'(doneQ[1]), 32'(51));
    end

    $display("[TB] randomized DUT truth tables");
    for (int r = 0; r < 6; r++) begin
      rtbl = 8'($urandom);
      applyStimulus("random", r % 2, rtbl, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Hardware counterpart to our combinational truth-table benches: drives every input vector into a combinational DUT, samples its single output and compares each sample against an expected truth table held in a parameter.
- Sits beside the DUT in FPGA/self-test builds.
- Reports pass/fail, a mismatch count and the first failing vector, so a combinational block can be exhaustively checked on silicon without a simulator.

Parameters:
- N_IN, 3, number of DUT inputs; sweep covers 2**N_IN vectors (legal range 1..6).
- EXPECTED, 8'hE8, expected truth table; bit k = required DUT output for input vector k (width 2**N_IN). Default is 3-input majority.
- SETTLE, 2, idle cycles the vector is held before sampling (legal 0..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- dut_in  out  N_IN  vector driven to the DUT; MSB is the DUT's first input (e.g. {A,B,C}).
- dut_out  in  1  DUT output (F).
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  high when the last completed sweep had zero mismatches; held until the next start is accepted.
- fail_count  out  N_IN+1  mismatches in the last or current sweep; saturates at 2**N_IN.
- first_fail_valid  out  1  at least one mismatch seen in this sweep.
- first_fail_vec  out  N_IN  vector index of the first mismatch; valid only when first_fail_valid=1.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE, dut_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_valid=0, first_fail_vec=0.
  - Settle counter and vector index are cleared.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge selects WAIT (or SAMPLE if SETTLE=0).
  - On that edge: vector index=0, dut_in=0, fail_count=0, first_fail_valid=0, pass=0, busy=1.
- WAIT:
  - dut_in is held stable.
  - The settle counter counts SETTLE cycles, then the FSM moves to SAMPLE.
- SAMPLE:
  - dut_out is compared with EXPECTED[index] at the closing edge.
  - On mismatch: fail_count increments. If first_fail_valid=0, first_fail_vec=index and first_fail_valid=1.
  - If index < 2**N_IN-1: index and dut_in increment, the settle counter clears, and the FSM returns to WAIT (or SAMPLE if SETTLE=0).
  - Otherwise the FSM moves to DONE. dut_in keeps its last value.
- DONE (1 cycle): done=1, busy=1, and pass=(fail_count==0) is registered. The next state is IDLE.
- Latency: with start accepted at edge 0, done is high during cycle 2**N_IN*(SETTLE+1)+1. For the defaults this is cycle 25; with SETTLE=0 it is cycle 9.
- start while busy (WAIT/SAMPLE/DONE) is ignored; it is not queued.
- start held high continuously starts a new sweep on the first IDLE cycle after DONE.
- The index must never wrap to 0 inside a sweep; the terminal compare uses the full index width.
- rst_n asserted mid-sweep aborts immediately to the reset values; results are not preserved.
- dut_out is used only in SAMPLE; its value in other states has no effect.
- All outputs are registered; there is no combinational path from dut_out to any output.

Test Plan:
1. Golden majority DUT, defaults, start pulsed at cycle 0 → dut_in steps 0..7, each value held 3 cycles; done at cycle 25; pass=1, fail_count=0, first_fail_valid=0.
2. Inverted-majority DUT → fail_count=8, first_fail_valid=1, first_fail_vec=3'b000, pass=0.
3. Majority DUT with output forced to 0 only at 3'b101 → fail_count=1, first_fail_vec=3'b101, pass=0; vector 3'b100 is checked as expected 0 and passes.
4. SETTLE=0 golden DUT → dut_in changes every cycle; done at cycle 9; pass=1. start re-pulsed at cycle 4 → ignored, and done occurs exactly once.
5. rst_n driven low at cycle 12 of a sweep, released at cycle 14 → all outputs return to reset values, no done pulse. A fresh start then completes normally with pass=1.
6. start held high across two sweeps with golden DUT → back-to-back sweeps, with done one cycle per sweep, one IDLE cycle between DONE and the next WAIT, and pass=1 after each.
